fifo_rr_wr_arbiter: RTL and testbench
=====================================

// Module: fifo_rr_wr_arbiter
// PURPOSE
//  Shares the write port of one sync FIFO (W-bit data, D entries) between NREQ producers.
//  - Arbitration is round-robin.
//  - The winner keeps the port for a burst of up to BURST beats, then the port is re-arbitrated.
//  - Drives the FIFO wen/din directly and back-pressures producers from the FIFO full flag.
//  - Sits between producer blocks and the FIFO write side; the FIFO read side is untouched.
// PARAMETERS
//  W      3   data width per beat; must match the FIFO W
//  NREQ   4   number of requesters, >=2; need not be a power of 2
//  BURST  4   max beats per grant, >=1
// PORTS
//  clk         in   1         clock, rising edge
//  rst_n       in   1         asynchronous active-low reset
//  req_valid   in   NREQ      producer i has a beat pending
//  req_data    in   NREQ*W    producer i data at [i*W +: W]
//  req_ready   out  NREQ      beat from producer i accepted this cycle (one-hot or 0)
//  fifo_full   in   1         FIFO full flag
//  fifo_wen    out  1         FIFO write enable
//  fifo_din    out  W         FIFO write data
//  owner       out  clog2(NREQ)  index of the current grant holder; valid when busy=1
//  busy        out  1         a grant is held (FSM in GRANT)
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - state=IDLE, ptr=0, owner=0, beat_cnt=0.
//   - busy=0, fifo_wen=0, req_ready=0; fifo_din=0.
//  State IDLE:
//   - No beats are accepted.
//   - If any req_valid: winner = first i with req_valid[i], scanning ptr, ptr+1, ... mod NREQ.
//   - Next cycle: state=GRANT, owner=winner, beat_cnt=0.
//  State GRANT:
//   - beat = req_valid[owner] & ~fifo_full.
//   - fifo_wen = req_ready[owner] = beat, all combinational in the same cycle.
//   - fifo_din = req_data[owner] whenever state=GRANT, else 0.
//  Release, GRANT->IDLE, ptr <= (owner+1) mod NREQ, triggered by either:
//   - (a) a beat while beat_cnt==BURST-1;
//   - (b) req_valid[owner]==0 in a cycle. No beat happens in that cycle.
//  - Otherwise, on a beat, beat_cnt++.
//  Throughput and timing:
//   - Bubble: exactly 1 idle cycle between grants; max throughput BURST/(BURST+1).
//   - Latency: req_valid rising in IDLE -> first possible fifo_wen 1 cycle later.
//  FIFO full while in GRANT:
//   - Grant is held; no beat; beat_cnt not incremented.
//   - Not a release cause; the stall may last indefinitely.
//  Producer contract:
//   - Producers hold req_valid/req_data until accepted.
//   - Dropping valid during GRANT is legal and causes release (b).
//  Invariants:
//   - Never fifo_wen while fifo_full.
//   - Never more than one req_ready bit set.
//   - req_ready only to owner.
//  Wrap-around: ptr and owner wrap NREQ-1 -> 0 (non-power-of-2 NREQ included).
//  Reset mid-burst: fifo_wen and req_ready drop immediately (async); partial burst discarded.
//  beat_cnt width: clog2(BURST)+1, no overflow.
// STRUCTURE
//  Package fifo_arb_pkg:
//   - typedef enum logic {IDLE, GRANT} arb_state_e;
//   - localparam functions for idx/count widths (clog2 with min 1).
//  Sub-module rr_pick (combinational rotating priority encoder):
//   - in: req[NREQ], ptr; out: any, idx.
//  Top: FSM, ptr/owner/beat_cnt registers, data mux, ready decode.
// TESTING
//  Bench instantiates this block driving a real FIFO (W=3, D=8) and checks FIFO output order.
//  1. Reset then idle: all req_valid=0 for 10 cycles -> busy=0, fifo_wen=0, req_ready=0, fifo_din=0.
//  2. Single producer:
//     - stimulus: req 2 streams 1..6, BURST=4;
//     - required: beats 1-4 back-to-back, 1 bubble, then regrant to 2 (only requester) for beats 5,6;
//     - required: FIFO reads 1,2,3,4,5,6.
//  3. All four requesters valid continuously, ptr=0:
//     - required: grant order 0,1,2,3,0 with 4 beats each and 1 bubble between;
//     - required: owner sequence checked.
//  4. Full stall:
//     - stimulus: fill FIFO to 8 entries with req 1 holding valid;
//     - required: fifo_wen=0 while full, busy=1, owner=1;
//     - stimulus: pop 2 entries;
//     - required: exactly 2 further beats accepted, no data lost or duplicated.
//  5. Early release:
//     - stimulus: req 0 drops valid after 2 beats;
//     - required: GRANT->IDLE next cycle, ptr=1, req 3 (only other valid) granted next.
//  6. Reset mid-burst:
//     - stimulus: assert rst_n=0 between clock edges after beat 2 of 4;
//     - required: fifo_wen=0 immediately; after release ptr=0 and arbitration restarts at req 0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the round-robin FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra bit so BURST-1 always fits, including BURST=1.
    function automatic int cnt_w(input int burst);
        return $clog2(burst) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first asserted req at or after ptr, wrapping mod NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan farthest offset first so the nearest hit to ptr wins last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i == ((int'(ptr) + k) % NREQ) && req[i]) begin
                    idx = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NREQ producers, bursts of up to BURST beats.
module fifo_rr_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int W     = 3,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*W-1:0]      req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wen,
    output logic [W-1:0]           fifo_din,
    output logic [idx_w(NREQ)-1:0] owner,
    output logic                   busy
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(BURST);

    arb_state_e    state, state_n;
    logic [IW-1:0] ptr, ptr_n, owner_n, owner_inc, pick_idx;
    logic [CW-1:0] beat_cnt, cnt_n;
    logic          pick_any, own_valid, beat;
    logic [W-1:0]  own_data;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == IW'(i)) begin
                own_valid = req_valid[i];
                own_data  = req_data[i*W +: W];
            end
        end
    end

    assign owner_inc = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign busy      = (state == GRANT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            beat_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        cnt_n     = beat_cnt;
        beat      = 1'b0;
        fifo_wen  = 1'b0;
        fifo_din  = '0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    owner_n = pick_idx;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                fifo_din  = own_data;
                beat      = own_valid & ~fifo_full;
                fifo_wen  = beat;
                req_ready = beat ? (NREQ'(1) << owner) : '0;
                // A full FIFO only stalls; release comes from a dropped valid or the last beat.
                if (!own_valid || (beat && beat_cnt == CW'(BURST - 1))) begin
                    state_n = IDLE;
                    ptr_n   = owner_inc;
                end else if (beat) begin
                    cnt_n = beat_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Bench: arbiter driving a small behavioural FIFO (W=3, D=8); table vectors plus scoreboarded corner sequences.
module tb_fifo_rr_wr_arbiter;

    localparam int W = 3, NREQ = 4, BURST = 4, D = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid;
    logic [11:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full, fifo_wen, busy;
    logic [2:0]  fifo_din;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    fifo_rr_wr_arbiter #(.W(W), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wen  (fifo_wen),
        .fifo_din  (fifo_din),
        .owner     (owner),
        .busy      (busy)
    );

    // Behavioural sync FIFO on the write side
    logic [2:0] fmem [D];
    logic [2:0] frp, fwp;
    int         fcount;
    logic       ren;

    assign fifo_full = (fcount == D);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frp    <= 3'd0;
            fwp    <= 3'd0;
            fcount <= 0;
        end else begin
            if (fifo_wen && fcount < D) begin
                fmem[fwp] <= fifo_din;
                fwp       <= fwp + 3'd1;
            end
            if (ren && fcount > 0) frp <= frp + 3'd1;
            fcount <= fcount + ((fifo_wen && fcount < D) ? 1 : 0) - ((ren && fcount > 0) ? 1 : 0);
        end
    end

    // Producers, scoreboard, table
    logic [2:0] pdata [NREQ][16];
    int         plen [NREQ];
    int         phead [NREQ];
    logic [3:0] en;

    typedef struct { logic [1:0] own; logic [2:0] data; } sb_t;
    sb_t        exp_q[$];
    logic [2:0] rd_exp_q[$];

    typedef struct { logic [3:0] valid; logic busy; logic [1:0] own; logic wen; logic [3:0] ready; } vec_t;
    vec_t vecs [36];

    int checks = 0, failures = 0;
    logic       s_busy, s_wen;
    logic [1:0] s_owner;
    logic [3:0] s_ready;
    logic [2:0] s_din;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (en[i] && phead[i] < plen[i]) begin
                req_valid[i]       = 1'b1;
                req_data[i*W +: W] = pdata[i][phead[i]];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*W +: W] = 3'd0;
            end
        end
    endtask

    task automatic load(input int i, input int n, input int start);
        for (int k = 0; k < n; k++) pdata[i][k] = 3'((start + k) & 7);
        plen[i]  = n;
        phead[i] = 0;
    endtask

    task automatic push_exp(input int i, input int k0, input int n);
        sb_t e;
        for (int k = k0; k < k0 + n; k++) begin
            e.own  = 2'(i);
            e.data = pdata[i][k];
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+1; samples at the falling edge, returns at the next posedge+1.
    task automatic cycle();
        logic [3:0] acc;
        sb_t        e;
        logic [2:0] rv;
        #4;
        s_busy = busy; s_wen = fifo_wen; s_owner = owner; s_ready = req_ready; s_din = fifo_din;
        check("inv_wen_while_full", {31'd0, fifo_wen & fifo_full}, 32'd0);
        check("inv_ready_decode", {28'd0, req_ready}, fifo_wen ? {28'd0, 4'(4'd1 << owner)} : 32'd0);
        if (fifo_wen) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected_write: got owner=%0d din=%0d expected no write", owner, fifo_din);
            end else begin
                e = exp_q.pop_front();
                check("sb_owner", {30'd0, owner}, {30'd0, e.own});
                check("sb_data", {29'd0, fifo_din}, {29'd0, e.data});
                rd_exp_q.push_back(e.data);
            end
        end
        if (ren && fcount > 0) begin
            if (rd_exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL fifo_rd_extra: got %0d expected empty FIFO", fmem[frp]);
            end else begin
                rv = rd_exp_q.pop_front();
                check("fifo_rd_order", {29'd0, fmem[frp]}, {29'd0, rv});
            end
        end
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i] && phead[i] < plen[i]) phead[i]++;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin plen[i] = 0; phead[i] = 0; end
        exp_q.delete();
        rd_exp_q.delete();
        ren = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 drive();
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int j = lo; j <= hi; j++) begin
            en = vecs[j].valid;
            drive();
            cycle();
            check("vec_busy", {31'd0, s_busy}, {31'd0, vecs[j].busy});
            check("vec_wen", {31'd0, s_wen}, {31'd0, vecs[j].wen});
            check("vec_ready", {28'd0, s_ready}, {28'd0, vecs[j].ready});
            if (vecs[j].busy) check("vec_owner", {30'd0, s_owner}, {30'd0, vecs[j].own});
            else              check("vec_din_idle", {29'd0, s_din}, 32'd0);
        end
    endtask

    initial begin
        int         nw;
        logic [11:0] wlog;
        logic [8:0]  blog, wl5;

        // Test 1 rows 0..9 idle; test 3 rows 10..35: bursts of 4 separated by one bubble
        for (int c = 0; c < 10; c++) vecs[c] = '{4'h0, 1'b0, 2'd0, 1'b0, 4'h0};
        for (int c = 0; c < 26; c++) begin
            logic b;
            logic [1:0] o;
            b = (c % 5 != 0) && (c < 25);
            o = 2'((c / 5) % 4);
            vecs[10 + c] = '{4'hF, b, o, b, b ? 4'(4'd1 << o) : 4'h0};
        end

        en = 4'h0; ren = 1'b0; req_valid = 4'h0; req_data = 12'h0;
        for (int i = 0; i < NREQ; i++) begin plen[i] = 0; phead[i] = 0; end

        // Test 1: reset state, then idle
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_wen", {31'd0, fifo_wen}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_din", {29'd0, fifo_din}, 32'd0);
        check("rst_owner", {30'd0, owner}, 32'd0);
        do_reset();
        run_vecs(0, 9);

        // Test 2: producer 2 alone streams 1..6
        do_reset();
        en = 4'hF;
        load(2, 6, 1); push_exp(2, 0, 6); drive();
        wlog = '0;
        for (int c = 0; c < 12; c++) begin cycle(); wlog[c] = s_wen; end
        check("t2_wen_pattern", {20'd0, wlog}, 32'h0DE);
        ren = 1'b1;
        repeat (7) cycle();
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_rd_empty", rd_exp_q.size(), 0);

        // Test 3: all four valid from ptr=0
        do_reset();
        ren = 1'b1;
        for (int i = 0; i < NREQ; i++) load(i, (i == 0) ? 8 : 4, 3 * i + 1);
        for (int b = 0; b < 4; b++) push_exp(b, 0, 4);
        push_exp(0, 4, 4);
        run_vecs(10, 35);
        check("t3_sb_empty", exp_q.size(), 0);

        // Test 4: fill FIFO from producer 1, stall, pop two
        do_reset();
        en = 4'hF;
        load(1, 10, 0); push_exp(1, 0, 10); drive();
        repeat (11) cycle();
        for (int c = 0; c < 6; c++) begin
            cycle();
            check("t4_stall_wen", {31'd0, s_wen}, 32'd0);
            check("t4_stall_busy", {31'd0, s_busy}, 32'd1);
            check("t4_stall_owner", {30'd0, s_owner}, 32'd1);
        end
        nw = 0;
        ren = 1'b1;
        repeat (2) begin cycle(); nw += int'(s_wen); end
        ren = 1'b0;
        repeat (6) begin cycle(); nw += int'(s_wen); end
        check("t4_extra_beats", nw, 2);
        ren = 1'b1;
        repeat (10) cycle();
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_rd_empty", rd_exp_q.size(), 0);

        // Test 5: producer 0 drops valid after two beats, producer 3 next
        do_reset();
        en = 4'hF; ren = 1'b1;
        load(0, 2, 5); load(3, 2, 1);
        push_exp(0, 0, 2); push_exp(3, 0, 2); drive();
        blog = '0; wl5 = '0;
        for (int c = 0; c < 9; c++) begin
            cycle();
            blog[c] = s_busy; wl5[c] = s_wen;
            if (c == 3) check("t5_held_owner", {30'd0, s_owner}, 32'd0);
            if (c == 5) check("t5_next_owner", {30'd0, s_owner}, 32'd3);
        end
        check("t5_busy_pattern", {23'd0, blog}, 32'h0EE);
        check("t5_wen_pattern", {23'd0, wl5}, 32'h066);
        check("t5_sb_empty", exp_q.size(), 0);

        // Test 6: move ptr to 3, start burst on 0, reset after beat 2
        do_reset();
        en = 4'hF;
        load(2, 1, 7); push_exp(2, 0, 1); drive();
        repeat (4) cycle();
        load(0, 4, 1); push_exp(0, 0, 4); drive();
        cycle();
        cycle();
        check("t6_pre_owner", {30'd0, s_owner}, 32'd0);
        cycle();
        #4;
        check("t6_beat3_pending", {31'd0, fifo_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_wen", {31'd0, fifo_wen}, 32'd0);
        check("t6_async_ready", {28'd0, req_ready}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        do_reset();
        en = 4'hF;
        load(0, 1, 3); load(3, 1, 6);
        push_exp(0, 0, 1); push_exp(3, 0, 1); drive();
        for (int c = 0; c < 7; c++) begin
            cycle();
            if (c == 1) check("t6_restart_owner", {30'd0, s_owner}, 32'd0);
            if (c == 4) check("t6_second_owner", {30'd0, s_owner}, 32'd3);
        end
        check("t6_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
